// File: rtl/bpb_pkg.sv
// Shared types for the branch prediction backend: 32-bit words, queued
// prediction entries and the default in-flight depth.
package bpb_pkg;

  localparam int BPB_H = 2;

  // Depth follows the predictor history width, capped so the queue stays small.
  localparam int DEFAULT_DEPTH = ((2 ** BPB_H) > 8) ? 8 : (2 ** BPB_H);

  typedef logic [31:0] Word;

  typedef struct packed {
    Word pc;
    Word instr;
    Word pred_pc;
  } PredEntry;

  function automatic logic is_mispredict(input Word actual, input Word predicted);
    return actual != predicted;
  endfunction

endpackage

// File: rtl/pred_fifo.sv
// Circular buffer of in-flight predictions; head is the oldest entry.
// The caller guarantees push is never asserted into a full queue without a pop.
module pred_fifo
  import bpb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  PredEntry      push_data,
  input  logic          pop,
  input  logic          flush,
  output PredEntry      head_data,
  output logic [CW-1:0] count,
  output logic          full
);

  PredEntry      mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;

  // NOTE: storage is deliberately left out of reset; only pointers and count
  // define which slots are valid, so resetting the array would only cost area.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= push_data;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= tail_ptr;
      count    <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_data = mem[head_ptr];
  assign full      = (count == CW'(DEPTH));

endmodule

// File: rtl/branch_resolve.sv
// Resolves queued front-end predictions against execute results and drives
// training feedback (miss/last_pc/last_instr) plus the fetch redirect.
module branch_resolve
  import bpb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          push,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_instr,
  input  logic [31:0]   push_pred_pc,
  output logic          full,
  output logic [CW-1:0] count,
  input  logic          resolve,
  input  logic [31:0]   actual_pc,
  output logic          miss,
  output logic [31:0]   redirect_pc,
  output logic [31:0]   last_pc,
  output logic [31:0]   last_instr,
  output logic          err
);

  PredEntry head_entry;
  PredEntry push_entry;
  logic     nonempty;
  logic     do_pop;
  logic     mis;
  logic     do_push;

  assign push_entry = '{pc: push_pc, instr: push_instr, pred_pc: push_pred_pc};
  assign nonempty   = (count != '0);
  assign do_pop     = en & resolve & nonempty;
  assign mis        = do_pop & is_mispredict(actual_pc, head_entry.pred_pc);
  // A full queue still takes a push when a correct resolve frees the head slot.
  assign do_push    = en & push & ~mis & (~full | do_pop);

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (do_push),
    .push_data (push_entry),
    .pop       (do_pop),
    .flush     (mis),
    .head_data (head_entry),
    .count     (count),
    .full      (full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      miss        <= 1'b0;
      err         <= 1'b0;
      redirect_pc <= '0;
      last_pc     <= '0;
      last_instr  <= '0;
    end else if (!en) begin
      miss <= 1'b0;
      err  <= 1'b0;
    end else begin
      miss <= mis;
      err  <= resolve & ~nonempty;
      if (mis) redirect_pc <= actual_pc;
      if (do_pop) begin
        last_pc    <= head_entry.pc;
        last_instr <= head_entry.instr;
      end
    end
  end

endmodule
